// File: rtl/dht11_pkg.sv
// Shared DHT11 definitions: FSM states, fixed protocol timings and frame length.
package dht11_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START_LOW,
      ST_RESP_WAIT,
      ST_RESP_LOW,
      ST_RESP_HIGH,
      ST_BIT_LOW,
      ST_BIT_HIGH,
      ST_END_LOW
   } dht11_state_e;

   localparam int unsigned RESP_LOW_US  = 80;
   localparam int unsigned RESP_HIGH_US = 80;
   localparam int unsigned BIT_LOW_US   = 50;
   localparam int unsigned END_LOW_US   = 50;
   localparam int unsigned SETTLE_US    = 2;
   localparam int unsigned FRAME_BITS   = 40;

   // Modulo-256 sum of the four data bytes.
   function automatic logic [7:0] dht11_checksum(input logic [7:0] a, input logic [7:0] b,
                                                  input logic [7:0] c, input logic [7:0] d);
      return a + b + c + d;
   endfunction

endpackage

// File: rtl/dht11_us_tick.sv
// Microsecond prescaler: tick_o is high on the last cycle of every DIV-cycle period.
// restart_i zeroes the count so a new phase always starts on a full period.
module dht11_us_tick #(
   parameter int unsigned DIV = 100
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic restart_i,
   output logic tick_o
);

   localparam int unsigned   CW   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // Next count: wrap at the end of a period or on restart.
   always_comb begin
      cnt_d = cnt_q + CW'(1);
      if (restart_i || (cnt_q == LAST)) cnt_d = '0;
   end

   // Count register.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

   assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/dht11_sensor_emu.sv
// DHT11 sensor emulator: answers a host start pulse with the 40-bit
// humidity/temperature frame on an open-drain one-wire bus.
module dht11_sensor_emu
   import dht11_pkg::*;
#(
   parameter int unsigned CLK_HZ        = 100_000_000,
   parameter int unsigned START_MIN_US  = 18000,
   parameter int unsigned BIT1_HIGH_US  = 70,
   parameter int unsigned BIT0_HIGH_US  = 27,
   parameter int unsigned RESP_DELAY_US = 30
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       w1_i,
   output logic       w1_oe_o,
   input  logic [7:0] hum_int_i,
   input  logic [7:0] hum_dec_i,
   input  logic [7:0] temp_int_i,
   input  logic [7:0] temp_dec_i,
   output logic       busy_o,
   output logic       done_o,
   output logic       abort_o
);

   localparam int unsigned DIV = CLK_HZ / 1_000_000;

   dht11_state_e state_q, state_d;
   logic         sync1_q, sync1_d, sync2_q, sync2_d, w1_prev_q, w1_prev_d;
   logic [15:0]  us_q, us_d;
   logic [5:0]   bit_q, bit_d;
   logic [39:0]  frame_q, frame_d;
   logic         oe_q, oe_d, busy_q, busy_d, done_q, done_d, abort_q, abort_d;

   logic w1_s, fall, rise, tick, restart, collide;

   assign w1_s    = sync2_q;
   assign fall    = w1_prev_q & ~w1_s;
   assign rise    = ~w1_prev_q & w1_s;
   assign restart = (state_d != state_q);
   // A low bus while released, once the line has had time to float back up,
   // means someone else is driving it.
   assign collide = (us_q >= 16'(SETTLE_US)) && !w1_s;

   dht11_us_tick #(.DIV(DIV)) u_tick (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .restart_i (restart),
      .tick_o    (tick)
   );

   // True on the final cycle of an n-microsecond phase.
   function automatic logic phase_end(input logic [15:0] us, input logic tk, input int unsigned n);
      return tk && (us == 16'(n - 1));
   endfunction

   // Next-state, counters, frame latch and registered outputs.
   always_comb begin
      sync1_d   = w1_i;
      sync2_d   = sync1_q;
      w1_prev_d = sync2_q;
      state_d   = state_q;
      bit_d     = bit_q;
      frame_d   = frame_q;
      done_d    = 1'b0;
      abort_d   = 1'b0;

      unique case (state_q)
         ST_IDLE: if (fall) state_d = ST_START_LOW;
         ST_START_LOW: begin
            if (rise) begin
               if (us_q >= 16'(START_MIN_US)) begin
                  state_d = ST_RESP_WAIT;
                  frame_d = {hum_int_i, hum_dec_i, temp_int_i, temp_dec_i,
                             dht11_checksum(hum_int_i, hum_dec_i, temp_int_i, temp_dec_i)};
                  bit_d   = '0;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         ST_RESP_WAIT: begin
            if (collide) begin
               state_d = ST_IDLE;
               abort_d = 1'b1;
            end else if (phase_end(us_q, tick, RESP_DELAY_US)) begin
               state_d = ST_RESP_LOW;
            end
         end
         ST_RESP_LOW: if (phase_end(us_q, tick, RESP_LOW_US)) state_d = ST_RESP_HIGH;
         ST_RESP_HIGH: begin
            if (collide) begin
               state_d = ST_IDLE;
               abort_d = 1'b1;
            end else if (phase_end(us_q, tick, RESP_HIGH_US)) begin
               state_d = ST_BIT_LOW;
            end
         end
         ST_BIT_LOW: if (phase_end(us_q, tick, BIT_LOW_US)) state_d = ST_BIT_HIGH;
         ST_BIT_HIGH: begin
            // frame_q[39] is always the bit on the wire; shift after each bit.
            if (collide) begin
               state_d = ST_IDLE;
               abort_d = 1'b1;
            end else if (phase_end(us_q, tick, frame_q[39] ? BIT1_HIGH_US : BIT0_HIGH_US)) begin
               frame_d = frame_q << 1;
               if (bit_q == 6'(FRAME_BITS - 1)) begin
                  state_d = ST_END_LOW;
               end else begin
                  state_d = ST_BIT_LOW;
                  bit_d   = bit_q + 6'd1;
               end
            end
         end
         ST_END_LOW: begin
            if (phase_end(us_q, tick, END_LOW_US)) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Microsecond counter saturates and restarts with every new state.
      us_d = us_q;
      if (tick && (us_q != 16'hFFFF)) us_d = us_q + 16'd1;
      if (restart) us_d = '0;

      oe_d   = (state_d == ST_RESP_LOW) || (state_d == ST_BIT_LOW) || (state_d == ST_END_LOW);
      busy_d = (state_d != ST_IDLE);
   end

   // State, synchronizer and output registers.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q   <= ST_IDLE;
         sync1_q   <= 1'b1;
         sync2_q   <= 1'b1;
         w1_prev_q <= 1'b1;
         us_q      <= '0;
         bit_q     <= '0;
         frame_q   <= '0;
         oe_q      <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         abort_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         w1_prev_q <= w1_prev_d;
         us_q      <= us_d;
         bit_q     <= bit_d;
         frame_q   <= frame_d;
         oe_q      <= oe_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         abort_q   <= abort_d;
      end
   end

   assign w1_oe_o = oe_q;
   assign busy_o  = busy_q;
   assign done_o  = done_q;
   assign abort_o = abort_q;

endmodule

// File: tb/tb_dht11_sensor_emu.sv
// Bench for dht11_sensor_emu: a host model drives start pulses and collisions,
// a monitor turns the bus waveform into events checked against an expected queue.
module tb_dht11_sensor_emu;

   localparam int CLK_HZ    = 2_000_000;
   localparam int DIV       = 2;
   localparam int START_MIN = 100;
   localparam int B1_US     = 70;
   localparam int B0_US     = 27;
   localparam int RD_US     = 30;

   localparam int EV_FIRST = 0;
   localparam int EV_LOW   = 1;
   localparam int EV_HIGH  = 2;
   localparam int EV_DONE  = 3;
   localparam int EV_ABORT = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       host_low = 1'b0;
   logic       w1, oe, busy, done, abort;
   logic [7:0] hi = 8'd0, hd = 8'd0, ti = 8'd0, td = 8'd0;

   // Open-drain bus with pull-up: low if either side drives.
   assign w1 = ~(oe | host_low);

   always #5 clk = ~clk;

   dht11_sensor_emu #(
      .CLK_HZ(CLK_HZ), .START_MIN_US(START_MIN),
      .BIT1_HIGH_US(B1_US), .BIT0_HIGH_US(B0_US), .RESP_DELAY_US(RD_US)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n), .w1_i(w1), .w1_oe_o(oe),
      .hum_int_i(hi), .hum_dec_i(hd), .temp_int_i(ti), .temp_dec_i(td),
      .busy_o(busy), .done_o(done), .abort_o(abort)
   );

   typedef struct {int kind; int lo; int hi;} ev_t;
   ev_t expq[$];
   int  tests = 0;
   int  fails = 0;

   function automatic void check(input string name, input int act, input int lo, input int hi_b);
      tests++;
      if (act < lo || act > hi_b) begin
         fails++;
         $display("FAIL %s: got %0d, want %0d..%0d", name, act, lo, hi_b);
      end
   endfunction

   function automatic void push_ev(input int k, input int lo, input int hi_b);
      ev_t e;
      e.kind = k; e.lo = lo; e.hi = hi_b;
      expq.push_back(e);
   endfunction

   // Reference model: the waveform a DHT11 frame must produce, as event widths in cycles.
   function automatic void push_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                                      input logic [7:0] d, input int abort_bit);
      logic [39:0] f;
      int cs;
      cs = (int'(a) + int'(b) + int'(c) + int'(d)) % 256;
      f = {a, b, c, d, 8'(cs)};
      push_ev(EV_FIRST, RD_US * DIV, RD_US * DIV + 4);
      push_ev(EV_LOW, 80 * DIV, 80 * DIV);
      push_ev(EV_HIGH, 80 * DIV, 80 * DIV);
      for (int i = 0; i < 40; i++) begin
         push_ev(EV_LOW, 50 * DIV, 50 * DIV);
         if (i == abort_bit) begin
            push_ev(EV_ABORT, 0, 0);
            return;
         end
         if (f[39 - i]) push_ev(EV_HIGH, B1_US * DIV, B1_US * DIV);
         else           push_ev(EV_HIGH, B0_US * DIV, B0_US * DIV);
      end
      push_ev(EV_LOW, 50 * DIV, 50 * DIV);
      push_ev(EV_DONE, 0, 0);
   endfunction

   function automatic void got_event(input int kind, input int val);
      ev_t e;
      tests++;
      if (expq.size() == 0) begin
         fails++;
         $display("FAIL unexpected_event: got kind %0d val %0d, want no event", kind, val);
      end else begin
         e = expq.pop_front();
         if (e.kind != kind || val < e.lo || val > e.hi) begin
            fails++;
            $display("FAIL bus_event: got kind %0d val %0d, want kind %0d val %0d..%0d",
                     kind, val, e.kind, e.lo, e.hi);
         end
      end
   endfunction

   // Monitor state
   logic oe_prev = 1'b0;
   logic had_low = 1'b0;
   logic in_rst  = 1'b1;
   int   run     = 0;
   int   bus_hi  = 0;

   // Monitor: decode DUT drive widths and pulses into events.
   always @(negedge clk) begin
      if (!rst_n) begin
         in_rst = 1'b1;
      end else if (in_rst) begin
         in_rst  = 1'b0;
         oe_prev = oe;
         run     = 1;
         had_low = 1'b0;
         bus_hi  = w1 ? 1 : 0;
      end else begin
         if (oe != oe_prev) begin
            if (oe) begin
               if (had_low) got_event(EV_HIGH, run);
               else         got_event(EV_FIRST, bus_hi);
            end else begin
               got_event(EV_LOW, run);
               had_low = 1'b1;
            end
            run = 1;
         end else begin
            run++;
         end
         oe_prev = oe;
         if (done)  got_event(EV_DONE, 0);
         if (abort) got_event(EV_ABORT, 0);
         if (done || abort) check("done_abort_excl", int'(done && abort), 0, 0);
         if (!busy) had_low = 1'b0;
         bus_hi = w1 ? bus_hi + 1 : 0;
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic host_start(input int us);
      cyc(1);
      host_low = 1'b1;
      cyc(us * DIV);
      host_low = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (busy && n < 30000) begin
         @(negedge clk);
         n++;
      end
      check({name, "_idle_timeout"}, int'(busy), 0, 0);
      cyc(20);
      check({name, "_oe_released"}, int'(oe), 0, 0);
      check({name, "_queue_drained"}, expq.size(), 0, 0);
   endtask

   task automatic wait_falls(input int n, input string name);
      int seen = 0;
      int c = 0;
      logic prev;
      prev = oe;
      while (seen < n && c < 20000) begin
         @(negedge clk);
         c++;
         if (prev && !oe) seen++;
         prev = oe;
      end
      check({name, "_falls"}, seen, n, n);
   endtask

   task automatic wait_rise(input string name);
      int c = 0;
      while (!oe && c < 20000) begin
         @(negedge clk);
         c++;
      end
      check({name, "_rise"}, int'(oe), 1, 1);
   endtask

   task automatic set_data(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                           input logic [7:0] d);
      hi = a; hd = b; ti = c; td = d;
   endtask

   initial begin
      #950_000;
      $display("FAIL watchdog: simulation did not finish, want finish before 950000 ns");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] r0, r1, r2, r3;
      // Reset state
      cyc(5);
      @(negedge clk);
      check("rst_oe", int'(oe), 0, 0);
      check("rst_busy", int'(busy), 0, 0);
      check("rst_done", int'(done), 0, 0);
      check("rst_abort", int'(abort), 0, 0);
      cyc(1);
      rst_n = 1'b1;
      cyc(20);

      // Nominal frame 45/0/27/3; temp_int changed during bit 10 must not leak.
      set_data(8'd45, 8'd0, 8'd27, 8'd3);
      push_frame(8'd45, 8'd0, 8'd27, 8'd3, -1);
      host_start(START_MIN + 20);
      wait_falls(12, "f1");
      cyc(1);
      ti = 8'd99;
      wait_idle("f1");
      ti = 8'd27;

      // Short starts, including just under the threshold: no response.
      host_start(START_MIN / 2);
      wait_idle("short");
      check("short_busy", int'(busy), 0, 0);
      host_start(START_MIN - 2);
      wait_idle("short_edge");

      // Checksum wrap-around.
      set_data(8'hFF, 8'hFF, 8'hFF, 8'h02);
      push_frame(8'hFF, 8'hFF, 8'hFF, 8'h02, -1);
      host_start(START_MIN + 2);
      wait_idle("wrap");

      // Collision in bit 5 high phase, then a fresh frame.
      r0 = 8'($urandom_range(0, 255)); r1 = 8'($urandom_range(0, 255));
      r2 = 8'($urandom_range(0, 255)); r3 = 8'($urandom_range(0, 255));
      set_data(r0, r1, r2, r3);
      push_frame(r0, r1, r2, r3, 5);
      host_start(START_MIN + 10);
      wait_falls(7, "coll");
      cyc(10 * DIV);
      host_low = 1'b1;
      cyc(20 * DIV);
      check("coll_oe", int'(oe), 0, 0);
      check("coll_busy", int'(busy), 0, 0);
      host_low = 1'b0;
      cyc(20);
      check("coll_queue_drained", expq.size(), 0, 0);
      r0 = 8'($urandom_range(0, 255)); r1 = 8'($urandom_range(0, 255));
      r2 = 8'($urandom_range(0, 255)); r3 = 8'($urandom_range(0, 255));
      set_data(r0, r1, r2, r3);
      push_frame(r0, r1, r2, r3, -1);
      host_start(START_MIN + 2 + int'($urandom_range(0, 40)));
      wait_idle("refresh");

      // Reset pulse during the response low phase.
      push_ev(EV_FIRST, RD_US * DIV, RD_US * DIV + 4);
      host_start(START_MIN + 5);
      wait_rise("rst");
      cyc(20 * DIV);
      rst_n = 1'b0;
      cyc(1);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_mid_oe", int'(oe), 0, 0);
      check("rst_mid_busy", int'(busy), 0, 0);
      cyc(300 * DIV);
      check("rst_mid_busy_late", int'(busy), 0, 0);
      check("rst_mid_queue_drained", expq.size(), 0, 0);

      // Random frame.
      r0 = 8'($urandom_range(0, 255)); r1 = 8'($urandom_range(0, 255));
      r2 = 8'($urandom_range(0, 255)); r3 = 8'($urandom_range(0, 255));
      set_data(r0, r1, r2, r3);
      push_frame(r0, r1, r2, r3, -1);
      host_start(START_MIN + 2 + int'($urandom_range(0, 40)));
      wait_idle("rand");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
